// File: rtl/uart_rx_axis.sv
// UART receiver: 16x oversampling, 3-sample majority vote, reset FIFO and an AXI-Stream master.
// Define UART_RX_BREAK_DET_EN to add break detection and the break_det output.
module uart_rx_axis #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] m_axis_tdata,
   output logic [1:0]           m_axis_tuser,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 overrun,
`ifdef UART_RX_BREAK_DET_EN
   output logic                 break_det,
`endif
   output logic                 busy
);

   localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int TW  = $clog2(DIV);
   localparam int OW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_BITS + 1);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int WW  = DATA_BITS + 2;

   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
   localparam logic [OW-1:0] OS_S0     = OW'(OVERSAMPLE / 2 - 1);
   localparam logic [OW-1:0] OS_S1     = OW'(OVERSAMPLE / 2);
   localparam logic [OW-1:0] OS_DEC    = OW'(OVERSAMPLE / 2 + 1);
   localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
   localparam bit            HAS_PAR   = (PARITY != 0);
   localparam bit            ODD_PAR   = (PARITY == 2);
   localparam bit            TWO_STOP  = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                state;
   logic                  rx_meta, rx_sync;
   logic [TW-1:0]         tick_cnt;
   logic [OW-1:0]         os_cnt;
   logic                  s0, s1, bit_val;
   logic [DATA_BITS-1:0]  shreg;
   logic [BW-1:0]         bit_cnt;
   logic                  stop_cnt;
   logic                  parity_err, frame_err;
`ifdef UART_RX_BREAK_DET_EN
   logic                  armed, par_bit, brk_frame;
`endif

   logic                  tick, at_dec, at_end, vote, start_go;
   logic                  frame_err_now, last_stop, push;
   logic [WW-1:0]         push_word;

   logic [WW-1:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic                  full, pop, wr_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments keep this a true two-stage shift; blocking would collapse it to one flop.
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   always_comb begin
      // NOTE: every signal in this block is assigned up front so no latch can be inferred.
      tick          = (tick_cnt == TICK_LAST);
      at_dec        = tick && (os_cnt == OS_DEC);
      at_end        = tick && (os_cnt == OS_LAST);
      vote          = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
      start_go      = (state == S_IDLE) && !rx_sync;
      frame_err_now = frame_err | ~vote;
      last_stop     = (state == S_STOP) && at_dec && (!TWO_STOP || stop_cnt);
      push_word     = {parity_err, frame_err_now, shreg};
      push          = last_stop;
`ifdef UART_RX_BREAK_DET_EN
      start_go      = start_go && armed;
      brk_frame     = (shreg == '0) && (!HAS_PAR || !par_bit) && frame_err_now;
      push          = last_stop && !brk_frame;
`endif
   end

   // Tick phase restarts at the falling edge so mid-bit samples line up with the start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  tick_cnt <= '0;
      else if (start_go || tick) tick_cnt <= '0;
      else                      tick_cnt <= tick_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         os_cnt     <= '0;
         s0         <= 1'b1;
         s1         <= 1'b1;
         bit_val    <= 1'b1;
         shreg      <= '0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         armed      <= 1'b1;
         par_bit    <= 1'b0;
         break_det  <= 1'b0;
`endif
      end else begin
`ifdef UART_RX_BREAK_DET_EN
         break_det <= 1'b0;
`endif
         if (tick) begin
            os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
            if (os_cnt == OS_S0)  s0      <= rx_sync;
            if (os_cnt == OS_S1)  s1      <= rx_sync;
            if (os_cnt == OS_DEC) bit_val <= vote;
         end
         case (state)
            S_IDLE: begin
               if (start_go) begin
                  state      <= S_START;
                  os_cnt     <= '0;
                  bit_cnt    <= '0;
                  stop_cnt   <= 1'b0;
                  parity_err <= 1'b0;
                  frame_err  <= 1'b0;
               end
`ifdef UART_RX_BREAK_DET_EN
               // After a break, rx must stay high for a whole bit time before re-arming.
               else if (!armed) begin
                  if (!rx_sync)                       os_cnt <= '0;
                  else if (tick && os_cnt == OS_LAST) armed  <= 1'b1;
               end
`endif
            end
            S_START: begin
               if (at_dec && vote) state <= S_IDLE;
               else if (at_end)    state <= S_DATA;
            end
            S_DATA: begin
               if (at_end) begin
                  shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == BIT_LAST) state <= HAS_PAR ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               if (at_end) begin
                  parity_err <= ((^shreg) ^ bit_val) != ODD_PAR;
`ifdef UART_RX_BREAK_DET_EN
                  par_bit    <= bit_val;
`endif
                  state      <= S_STOP;
               end
            end
            S_STOP: begin
               // With two stop bits the first is judged at its end; the last at mid-bit so a
               // start bit right behind it is not missed.
               if (TWO_STOP && !stop_cnt) begin
                  if (at_end) begin
                     if (!bit_val) frame_err <= 1'b1;
                     stop_cnt <= 1'b1;
                  end
               end else if (at_dec) begin
                  state <= S_IDLE;
`ifdef UART_RX_BREAK_DET_EN
                  if (brk_frame) begin
                     break_det <= 1'b1;
                     armed     <= 1'b0;
                     os_cnt    <= '0;
                  end
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state != S_IDLE);

   assign full  = (count == FIFO_FULL);
   assign pop   = m_axis_tvalid && m_axis_tready;
   assign wr_en = push && (!full || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: storage is reset so tdata/tuser read 0 rather than X straight out of reset.
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         overrun <= push && full && !pop;
         if (wr_en) begin
            mem[wr_ptr] <= push_word;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign m_axis_tvalid = (count != '0);
   assign m_axis_tdata  = mem[rd_ptr][DATA_BITS-1:0];
   assign m_axis_tuser  = mem[rd_ptr][WW-1:DATA_BITS];

endmodule

// File: tb/tb_uart_rx_axis.sv
// Bench for uart_rx_axis: a no-parity and an even-parity instance driven with directed and random
// frames; expected beats come from a frame-level model of the line format.
module tb_uart_rx_axis;

   localparam int BIT_CLKS = 432;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx0, rx1, tready0, tready1;
   logic [7:0] tdata0, tdata1;
   logic [1:0] tuser0, tuser1;
   logic       tvalid0, tvalid1, overrun0, overrun1, busy0, busy1;
`ifdef UART_RX_BREAK_DET_EN
   logic       brk0, brk1;
`endif

   uart_rx_axis #(.PARITY(0)) dut0 (
      .clk(clk), .rst(rst), .rx(rx0),
      .m_axis_tdata(tdata0), .m_axis_tuser(tuser0), .m_axis_tvalid(tvalid0),
      .m_axis_tready(tready0), .overrun(overrun0),
`ifdef UART_RX_BREAK_DET_EN
      .break_det(brk0),
`endif
      .busy(busy0)
   );

   uart_rx_axis #(.PARITY(1)) dut1 (
      .clk(clk), .rst(rst), .rx(rx1),
      .m_axis_tdata(tdata1), .m_axis_tuser(tuser1), .m_axis_tvalid(tvalid1),
      .m_axis_tready(tready1), .overrun(overrun1),
`ifdef UART_RX_BREAK_DET_EN
      .break_det(brk1),
`endif
      .busy(busy1)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [9:0] obs0[$], obs1[$], exp0[$], exp1[$], model_q[$];
   int         ovr0 = 0;
   int         model_ovr;
   logic       busy_seen0 = 1'b0;

   // Beat monitor: records every accepted AXIS word as {tuser, tdata}.
   always @(negedge clk) begin
      #1;
      if (tvalid0 && tready0) obs0.push_back({tuser0, tdata0});
      if (tvalid1 && tready1) obs1.push_back({tuser1, tdata1});
      if (overrun0) ovr0++;
      if (busy0) busy_seen0 = 1'b1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame-level reference: parity error from the ones count, frame error from the stop level.
   function automatic logic [9:0] model_beat(input int parity_mode, input logic [7:0] d,
                                             input logic pbit, input logic stop);
      int   ones = $countones(d) + int'(pbit);
      logic perr = 1'b0;
      if (parity_mode == 1) perr = (ones % 2) != 0;
      if (parity_mode == 2) perr = (ones % 2) == 0;
      return {perr, ~stop, d};
   endfunction

   task automatic drive(input int sel, input logic b);
      @(negedge clk);
      if (sel == 0) rx0 = b;
      else          rx1 = b;
      repeat (BIT_CLKS - 1) @(negedge clk);
   endtask

   task automatic send_frame(input int sel, input logic [7:0] d, input logic pbit, input logic stop);
      drive(sel, 1'b0);
      for (int i = 0; i < 8; i++) drive(sel, d[i]);
      if (sel == 1) drive(sel, pbit);
      drive(sel, stop);
      drive(sel, 1'b1);
   endtask

   task automatic drain_check(input int sel, input string tag);
      logic [9:0] e, o;
      int         waited, avail;
      while (((sel == 0) ? exp0.size() : exp1.size()) != 0) begin
         waited = 0;
         avail  = (sel == 0) ? obs0.size() : obs1.size();
         while (avail == 0 && waited < 2000) begin
            @(negedge clk);
            waited++;
            avail = (sel == 0) ? obs0.size() : obs1.size();
         end
         if (sel == 0) e = exp0.pop_front();
         else          e = exp1.pop_front();
         check({tag, "_present"}, 32'(avail != 0), 1);
         if (avail != 0) begin
            if (sel == 0) o = obs0.pop_front();
            else          o = obs1.pop_front();
            check(tag, 32'(o), 32'(e));
         end
      end
   endtask

   initial begin
      logic [7:0] d;
      logic       pbit, stop;

      rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; tready0 = 1'b1; tready1 = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("rst_tvalid0",  32'(tvalid0),  0);
      check("rst_tdata0",   32'(tdata0),   0);
      check("rst_tuser0",   32'(tuser0),   0);
      check("rst_overrun0", 32'(overrun0), 0);
      check("rst_busy0",    32'(busy0),    0);
      check("rst_tvalid1",  32'(tvalid1),  0);
      check("rst_tdata1",   32'(tdata1),   0);
      check("rst_busy1",    32'(busy1),    0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Even parity: correct parity bit, then a wrong one.
      exp1.push_back(model_beat(1, 8'hA5, 1'b0, 1'b1));
      send_frame(1, 8'hA5, 1'b0, 1'b1);
      drain_check(1, "par_ok");
      check("par_ok_single", 32'(obs1.size()), 0);
      exp1.push_back(model_beat(1, 8'hA5, 1'b1, 1'b1));
      send_frame(1, 8'hA5, 1'b1, 1'b1);
      drain_check(1, "par_err");

      // Framing error, then a clean frame.
      exp0.push_back(model_beat(0, 8'h3C, 1'b0, 1'b0));
      send_frame(0, 8'h3C, 1'b0, 1'b0);
      drain_check(0, "frame_err");
      exp0.push_back(model_beat(0, 8'h55, 1'b0, 1'b1));
      send_frame(0, 8'h55, 1'b0, 1'b1);
      drain_check(0, "frame_ok");

      // Glitch shorter than half a bit is rejected as a false start.
      busy_seen0 = 1'b0;
      @(negedge clk);
      rx0 = 1'b0;
      repeat (100) @(negedge clk);
      rx0 = 1'b1;
      repeat (600) @(negedge clk);
      #1;
      check("glitch_busy_seen", 32'(busy_seen0), 1);
      check("glitch_busy_idle", 32'(busy0),      0);
      check("glitch_tvalid",    32'(tvalid0),    0);
      check("glitch_no_beat",   32'(obs0.size()), 0);

      // Random frames with occasional parity or stop errors.
      for (int k = 0; k < 4; k++) begin
         d    = 8'($urandom_range(0, 255));
         pbit = (^d) ^ ($urandom_range(0, 2) == 0);
         stop = ($urandom_range(0, 3) != 0);
         exp1.push_back(model_beat(1, d, pbit, stop));
         send_frame(1, d, pbit, stop);
         drain_check(1, "rand");
      end

      // Back-pressure: five frames into a four-entry FIFO.
      tready0   = 1'b0;
      ovr0      = 0;
      model_ovr = 0;
      model_q.delete();
      for (int k = 1; k <= 5; k++) begin
         d = 8'(k);
         if (model_q.size() < 4) model_q.push_back(model_beat(0, d, 1'b0, 1'b1));
         else                    model_ovr++;
         send_frame(0, d, 1'b0, 1'b1);
      end
      #1;
      check("ovr_pulses",  32'(ovr0),    32'(model_ovr));
      check("ovr_tvalid",  32'(tvalid0), 1);
      check("ovr_head",    32'(tdata0),  32'(model_q[0][7:0]));
      check("ovr_no_beat", 32'(obs0.size()), 0);
      @(negedge clk);
      tready0 = 1'b1;
      repeat (20) @(negedge clk);
      while (model_q.size() != 0) exp0.push_back(model_q.pop_front());
      drain_check(0, "drain");
      #1;
      check("drain_tvalid", 32'(tvalid0), 0);
      check("drain_extra",  32'(obs0.size()), 0);

      // Reset in the middle of data bit 3 drops the frame; the next frame is clean.
      d = 8'h96;
      drive(0, 1'b0);
      for (int i = 0; i < 3; i++) drive(0, d[i]);
      @(negedge clk);
      rx0 = d[3];
      repeat (200) @(negedge clk);
      #1;
      check("mid_busy", 32'(busy0), 1);
      @(negedge clk);
      rst = 1'b1;
      rx0 = 1'b1;
      #1;
      check("mid_rst_tvalid", 32'(tvalid0), 0);
      check("mid_rst_busy",   32'(busy0),   0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2 * BIT_CLKS) @(negedge clk);
      exp0.push_back(model_beat(0, d, 1'b0, 1'b1));
      send_frame(0, d, 1'b0, 1'b1);
      drain_check(0, "after_rst");
      check("after_rst_extra", 32'(obs0.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
